// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: reads imem at PC, buffers the word for decode,
// then pulses updatePC (with optional relative jump) to advance the PC unit.
module fetch_sequencer #(
  parameter logic [3:0] JMP_OP  = 4'hC,
  parameter logic [3:0] HALT_OP = 4'hF
) (
  input  logic        Clk2,
  input  logic        reset_n,
  input  logic [15:0] PC,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ready,
  input  logic [15:0] imem_data,
  output logic [15:0] instr,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic        updatePC,
  output logic        jump,
  output logic [5:0]  offset,
  output logic        halted
);

  localparam int unsigned DATA_W = 16;
  localparam int unsigned OFF_W  = 6;

  typedef enum logic [1:0] {
    ST_FETCH   = 2'd0,
    ST_ADVANCE = 2'd1,
    ST_HALTED  = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [DATA_W-1:0] instr_q, instr_d;
  logic              instr_valid_q, instr_valid_d;
  logic              update_q, update_d;
  logic              jump_q, jump_d;
  logic [OFF_W-1:0]  offset_q, offset_d;
  logic              halted_q, halted_d;

  logic       fire_c;
  logic [3:0] opcode_c;
  logic       is_halt_c;
  logic       is_jmp_c;

  // Request may overlap a same-cycle drain; forced low while reset is held.
  assign imem_req  = reset_n && (state_q == ST_FETCH) && (!instr_valid_q || instr_ready);
  assign imem_addr = PC;

  // Fetch completion and opcode decode of the returned word.
  assign fire_c    = imem_req && imem_ready;
  assign opcode_c  = imem_data[15:12];
  assign is_halt_c = (opcode_c == HALT_OP);
  assign is_jmp_c  = (opcode_c == JMP_OP);

  // State register.
  always_ff @(posedge Clk2 or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: one ADVANCE cycle per non-HALT fetch; HALTED is terminal.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_FETCH: begin
        if (fire_c) begin
          state_d = is_halt_c ? ST_HALTED : ST_ADVANCE;
        end
      end
      ST_ADVANCE: state_d = ST_FETCH;
      ST_HALTED:  state_d = ST_HALTED;
      default:    state_d = ST_FETCH;
    endcase
  end

  // Output next-values: buffer fill/drain and the PC-advance controls.
  always_comb begin
    instr_d       = instr_q;
    instr_valid_d = instr_valid_q;
    update_d      = 1'b0;
    jump_d        = 1'b0;
    offset_d      = '0;
    halted_d      = halted_q;
    if (fire_c) begin
      instr_d       = imem_data;
      instr_valid_d = 1'b1;
      if (is_halt_c) begin
        halted_d = 1'b1;
      end else begin
        update_d = 1'b1;
        if (is_jmp_c) begin
          jump_d   = 1'b1;
          offset_d = imem_data[OFF_W-1:0];
        end
      end
    end else if (instr_valid_q && instr_ready) begin
      instr_valid_d = 1'b0;
    end
  end

  // Registered outputs.
  always_ff @(posedge Clk2 or negedge reset_n) begin
    if (!reset_n) begin
      instr_q       <= '0;
      instr_valid_q <= 1'b0;
      update_q      <= 1'b0;
      jump_q        <= 1'b0;
      offset_q      <= '0;
      halted_q      <= 1'b0;
    end else begin
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      update_q      <= update_d;
      jump_q        <= jump_d;
      offset_q      <= offset_d;
      halted_q      <= halted_d;
    end
  end

  assign instr       = instr_q;
  assign instr_valid = instr_valid_q;
  assign updatePC    = update_q;
  assign jump        = jump_q;
  assign offset      = offset_q;
  assign halted      = halted_q;

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Instruction-fetch sequencer on the consumer side of the PC update unit. Each fetch reads instruction memory at the current `PC` and hands the instruction to decode through a one-entry valid/ready buffer. It then drives back the `updatePC`, `jump` and `offset` controls that advance `PC`, either by +1 or by a sign-extended 6-bit relative jump. It sits between the PC unit, instruction memory and the decode stage.

## Interface
Parameters:
- `JMP_OP`, default 4'hC: opcode (`instr[15:12]`) of the unconditional relative jump; target offset is `instr[5:0]`.
- `HALT_OP`, default 4'hF: opcode that stops fetching.

Ports (one clock; reset is asynchronous and active-low):
- `Clk2`  input  1  system clock; all state changes on rising edge.
- `reset_n`  input  1  asynchronous, active-low reset.
- `PC`  input  16  current program counter from the PC unit.
- `imem_req`  output  1  fetch request to instruction memory.
- `imem_addr`  output  16  fetch address; equals `PC` whenever `imem_req`=1.
- `imem_ready`  input  1  memory returns `imem_data` this cycle, completing the request.
- `imem_data`  input  16  fetched instruction; valid only when `imem_req`&&`imem_ready`.
- `instr`  output  16  buffered instruction to decode.
- `instr_valid`  output  1  `instr` holds an undelivered instruction.
- `instr_ready`  input  1  decode accepts `instr` this cycle.
- `updatePC`  output  1  one-cycle pulse telling the PC unit to advance.
- `jump`  output  1  with `updatePC`: PC ← PC + sext(`offset`); else PC ← PC + 1.
- `offset`  output  6  two's-complement relative jump distance.
- `halted`  output  1  a HALT has been fetched; no further fetches.

## Operation
- States: FETCH, ADVANCE, HALTED. Reset state is FETCH.
- **FETCH**
  - `imem_req` = !`instr_valid` || `instr_ready`. This is combinational: a fetch may overlap a same-cycle drain of the buffer.
  - `imem_addr` = `PC` (combinational).
  - On `imem_req`&&`imem_ready`: latch `imem_data` into `instr`, set `instr_valid`.
  - If opcode == `HALT_OP`, go to HALTED. Otherwise go to ADVANCE.
  - In ADVANCE, register `updatePC`=1. If opcode == `JMP_OP`, also register `jump`=1 and `offset`=`imem_data[5:0]`; otherwise `jump`=0 and `offset`=0.
- **ADVANCE**
  - Lasts exactly one cycle.
  - `updatePC`/`jump`/`offset` are asserted from registers during this cycle; `imem_req`=0.
  - Next state is FETCH; the PC unit updates on the ending edge.
- **HALTED**
  - `imem_req`=0, `updatePC`=0, `halted`=1. `PC` is not advanced past the HALT.
  - The HALT instruction is still delivered through the buffer.
  - Exit only by reset.
- **Buffer**
  - On `instr_valid`&&`instr_ready`, `instr_valid` clears unless a new fetch completes in the same cycle; in that case it stays 1 and `instr` takes the new data.
  - `instr` is stable while `instr_valid`=1 and `instr_ready`=0.
- `updatePC` is never asserted outside ADVANCE, and never twice for one fetch.
- `jump` and `offset` return to 0 whenever `updatePC`=0.
- Offset arithmetic belongs to the PC unit. This block passes `imem_data[5:0]` unmodified; the range is −32..+31, wrap at 16 bits.
- A jump with offset 0 produces a self-loop; it is legal and repeats indefinitely.

## Timing
- **Reset values** (`reset_n`=0, asynchronous): state=FETCH, `instr`=0, `instr_valid`=0, `updatePC`=0, `jump`=0, `offset`=0, `halted`=0. `imem_req` reads 0 while `reset_n`=0.
- **Reset mid-operation:** any outstanding request is abandoned immediately, and a buffered instruction is discarded. Memory must tolerate `imem_req` dropping without `imem_ready`.
- **Latency:**
  - Fetch completes at edge E0. `instr_valid` and `updatePC` are high in cycle E0..E1.
  - New `PC` is visible after E1, and the next `imem_req` can assert in cycle E1..E2.
  - Throughput: at most one instruction per 2 cycles with zero-wait memory.
- **Wait states:** `imem_req` and `imem_addr` hold steady while `imem_ready`=0.
- **Backpressure:** with `instr_valid`=1 and `instr_ready`=0 in FETCH, `imem_req`=0 and the state machine idles in FETCH.
- **`imem_ready` without `imem_req`:** ignored.

## Test plan
- **Reset + linear fetch.** Stimulus: reset, PC=0x0000, memory zero-wait with NOPs (opcode 0), `instr_ready`=1. Required: requests at addresses 0,1,2,3 on every other cycle; `updatePC` pulses with `jump`=0; `instr` matches memory contents in order.
- **Forward/back jump.** Stimulus: word 0x0005 = {`JMP_OP`, 6'b111101}. Required: `updatePC`=1, `jump`=1, `offset`=6'h3D for one cycle; next request at PC 0x0002 (driven by the PC-unit model).
- **Memory wait states.** Stimulus: `imem_ready` low for 3 cycles. Required: `imem_addr` stable and `imem_req` held for 4 cycles; exactly one `updatePC` pulse.
- **Decode backpressure.** Stimulus: `instr_ready`=0 for 5 cycles after a fetch. Required: `instr` unchanged, no new `imem_req`. When `instr_ready` rises, a fetch overlaps the drain and `instr_valid` stays 1 with the new word.
- **HALT.** Stimulus: HALT_OP at 0x0003. Required: HALT word delivered, `halted`=1, `updatePC` never pulses for it, PC stays 0x0003, no further requests for 20 cycles.
- **Async reset mid-wait.** Stimulus: assert `reset_n`=0 mid-cycle during a pending request. Required: `imem_req`, `instr_valid` and `updatePC` all 0 before the next edge; fetching restarts from the PC-unit reset value once `reset_n` rises.
